// File: rtl/dota_row_mac.sv
// rtl/dota_row_mac.sv - row walker over dataA with signed four-wide multiply-accumulate
module dota_row_mac #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int BEATS  = 4,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  input  logic [DATA_W-1:0] q3,
  input  logic [DATA_W-1:0] q4,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] b3,
  input  logic [DATA_W-1:0] b4,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid
);

  localparam int CNT_W  = 6;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  issue_cnt;
  logic              pipe;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] qv [4];
  logic [DATA_W-1:0] bv [4];
  logic [SUM_W-1:0]  beat_sum;
  logic [ACC_W-1:0]  beat_ext;

  assign qv[0] = q1;
  assign qv[1] = q2;
  assign qv[2] = q3;
  assign qv[3] = q4;
  assign bv[0] = b1;
  assign bv[1] = b2;
  assign bv[2] = b3;
  assign bv[3] = b4;

  assign busy = (state != IDLE);

  // Signed sum of the four word products of the beat currently on q/b.
  // Operands are sign-extended to the product width so the truncated
  // product is the exact two's-complement result.
  always_comb begin
    logic [PROD_W-1:0] qa;
    logic [PROD_W-1:0] ba;
    logic [PROD_W-1:0] prod;
    beat_sum = '0;
    for (int i = 0; i < 4; i++) begin
      qa       = {{DATA_W{qv[i][DATA_W-1]}}, qv[i]};
      ba       = {{DATA_W{bv[i][DATA_W-1]}}, bv[i]};
      prod     = qa * ba;
      beat_sum = beat_sum + {{2{prod[PROD_W-1]}}, prod};
    end
    beat_ext = {{(ACC_W-SUM_W){beat_sum[SUM_W-1]}}, beat_sum};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: ISSUE lasts BEATS cycles, DRAIN one cycle for the last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (issue_cnt == CNT_W'(BEATS - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk, beat-valid pipe flag, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr      <= '0;
      issue_cnt    <= '0;
      pipe         <= 1'b0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      // Data on q/b next cycle belongs to this row only if dataA sampled
      // one of our addresses at this edge.
      pipe         <= (state == ISSUE);
      case (state)
        IDLE: begin
          if (start) begin
            rd_addr   <= base_addr;
            acc       <= '0;
            issue_cnt <= '0;
          end
        end
        ISSUE: begin
          rd_addr   <= rd_addr + ADDR_W'(4);
          issue_cnt <= issue_cnt + CNT_W'(1);
          if (pipe) acc <= acc + beat_ext;
        end
        DRAIN: begin
          result       <= pipe ? (acc + beat_ext) : acc;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dota_row_mac.sv
// tb/tb_dota_row_mac.sv - randomized and directed check of dota_row_mac against a dot-product model
module tb_dota_row_mac;

  localparam int BEATS = 4;
  localparam int WORDS = 4 * BEATS;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  rd_addr;
  logic [15:0] q1, q2, q3, q4, b1, b2, b3, b4;
  logic        busy;
  logic [39:0] result;
  logic        result_valid;

  dota_row_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .rd_addr(rd_addr),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .busy(busy), .result(result), .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Dot product of the 16 consecutive (mod 256) row words starting at base.
  function automatic logic [39:0] dot(input logic [7:0] base);
    longint s;
    logic [7:0] a;
    s = 0;
    for (int j = 0; j < WORDS; j++) begin
      a = base + 8'(j);
      s += longint'($signed(mem_a[a])) * longint'($signed(mem_b[a]));
    end
    return s[39:0];
  endfunction

  // dataA / B side: synchronous read of the address presented before each edge.
  logic [7:0] cap_addr = 8'd0;
  always @(negedge clk) cap_addr = rd_addr;
  always @(posedge clk) begin
    #1;
    q1 = mem_a[cap_addr];          b1 = mem_b[cap_addr];
    q2 = mem_a[cap_addr + 8'd1];   b2 = mem_b[cap_addr + 8'd1];
    q3 = mem_a[cap_addr + 8'd2];   b3 = mem_b[cap_addr + 8'd2];
    q4 = mem_a[cap_addr + 8'd3];   b4 = mem_b[cap_addr + 8'd3];
  end

  // Model: a row accepted in idle completes BEATS+1 cycles later with dot(base).
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [39:0] m_result = '0;
  logic [39:0] m_pending = '0;
  logic [7:0]  m_addr = '0;
  always @(posedge clk) begin
    bit idle_before;
    if (!rst_n) begin
      m_cnt = 0; m_valid = 1'b0; m_result = '0; m_addr = '0;
    end else begin
      idle_before = (m_cnt == 0);
      m_valid = 1'b0;
      if (m_cnt > 1) m_addr = m_addr + 8'd4;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid  = 1'b1;
          m_result = m_pending;
        end
      end
      if (idle_before && start) begin
        m_cnt     = BEATS + 1;
        m_pending = dot(base_addr);
        m_addr    = base_addr;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check(busy == (m_cnt != 0), "busy", 64'(busy), 64'(m_cnt != 0));
      check(result_valid == m_valid, "result_valid", 64'(result_valid), 64'(m_valid));
      check(result == m_result, "result", 64'(result), 64'(m_result));
      check(rd_addr == m_addr, "rd_addr", 64'(rd_addr), 64'(m_addr));
    end
  end

  logic [7:0] seq [4];

  task automatic start_row(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input logic [39:0] lit, input string nm, input int exp_n);
    int n;
    bit got;
    n = 0;
    got = 0;
    seq[0] = rd_addr;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (n < 4) seq[n] = rd_addr;
      if (result_valid) got = 1;
    end
    check(got && n == exp_n, {nm, "_latency"}, 64'(n), 64'(exp_n));
    check(result == lit, nm, 64'(result), 64'(lit));
  endtask

  task automatic fill(input logic [7:0] b, input logic [15:0] qa, input logic [15:0] qb, input bit ramp);
    for (int j = 0; j < WORDS; j++) begin
      mem_a[8'(b + 8'(j))] = ramp ? 16'(j + 1) : qa;
      mem_b[8'(b + 8'(j))] = qb;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    @(negedge clk); @(negedge clk);
    check(rd_addr == 8'd0, "reset_rd_addr", 64'(rd_addr), 0);
    check(busy == 1'b0, "reset_busy", 64'(busy), 0);
    check(result == 40'd0, "reset_result", 64'(result), 0);
    check(result_valid == 1'b0, "reset_valid", 64'(result_valid), 0);
    rst_n = 1'b1;
    cmp_en = 1;
    @(negedge clk);

    // Basic ramp row
    fill(8'h00, 16'd0, 16'd1, 1);
    check(dot(8'h00) == 40'd136, "model_basic", 64'(dot(8'h00)), 136);
    start_row(8'h00);
    wait_result(40'd136, "basic", 5);
    check({seq[0], seq[1], seq[2], seq[3]} == 32'h00040_80C, "basic_addr_seq",
          64'({seq[0], seq[1], seq[2], seq[3]}), 64'h0004080C);

    // Signed
    fill(8'h00, 16'hFFFF, 16'd3, 0);
    check(dot(8'h00) == 40'hFF_FFFF_FFD0, "model_signed", 64'(dot(8'h00)), 64'hFFFFFFFFD0);
    start_row(8'h00);
    wait_result(40'hFF_FFFF_FFD0, "signed", 5);

    // Largest products
    fill(8'h00, 16'h8000, 16'h8000, 0);
    start_row(8'h00);
    wait_result(40'h04_0000_0000, "overflow", 5);

    // Address wrap
    for (int j = 0; j < 8; j++) begin
      mem_a[8'hF8 + j] = 16'd2; mem_b[8'hF8 + j] = 16'd1;
      mem_a[j] = 16'd3;         mem_b[j] = 16'd1;
    end
    mem_a[8] = 16'd100; mem_b[8] = 16'd1;
    start_row(8'hF8);
    wait_result(40'd40, "wrap", 5);
    check({seq[0], seq[1], seq[2], seq[3]} == 32'hF8FC_0004, "wrap_addr_seq",
          64'({seq[0], seq[1], seq[2], seq[3]}), 64'hF8FC0004);

    // start while busy ignored
    fill(8'h00, 16'd0, 16'd1, 1);
    fill(8'h40, 16'd2, 16'd5, 0);
    start_row(8'h00);
    start = 1'b1; base_addr = 8'h40;
    @(negedge clk);
    start = 1'b0;
    wait_result(40'd136, "busy_ignore", 4);

    // back-to-back: start in the result_valid cycle
    start_row(8'h40);
    wait_result(40'd160, "back_to_back", 5);

    // reset mid-row
    start_row(8'h00);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(rd_addr == 8'd0, "midreset_rd_addr", 64'(rd_addr), 0);
    check(busy == 1'b0, "midreset_busy", 64'(busy), 0);
    check(result == 40'd0, "midreset_result", 64'(result), 0);
    check(result_valid == 1'b0, "midreset_valid", 64'(result_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(result_valid == 1'b0, "midreset_no_pulse", 64'(result_valid), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_row(8'h00);
    wait_result(40'd136, "after_reset", 5);

    // Randomized rows with random start pressure
    @(negedge clk); @(negedge clk); @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 2) == 0);
      base_addr = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
